// File: rtl/axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_if
// AXI4 channel bundle used by the axi_lite_master block and its bus partners.
// Only single-beat (AXI4-Lite style) traffic is carried, but the full AXI4
// sideband fields are present so the bundle plugs into a standard interconnect.
//
// Parameters:
//   AXI_ADDR_WIDTH  address width of AW/AR
//   AXI_DATA_WIDTH  data width of W/R; strobe width is AXI_DATA_WIDTH/8
//   AXI_ID_WIDTH    ID width on all channels
//   AXI_USER_WIDTH  user sideband width on all channels
//
// Modports:
//   master  initiator side: drives AW/W/AR payload and valids, B/R readies
//   slave   target side:    drives AW/W/AR readies, B/R payload and valids
// -----------------------------------------------------------------------------
interface axi_lite_master_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  // write address channel
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  // write data channel
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  // write response channel
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  // read address channel
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  // read data channel
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Turns a memory-like req/gnt/rvalid interface into single-beat AXI4-Lite
// read and write transactions. One transaction is in flight at a time; the
// AW and W channels of a write are handshaken independently.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   req_i     request valid, held until gnt_o
//   we_i      1 = write, 0 = read
//   addr_i    byte address
//   wdata_i   write data
//   be_i      byte enables, used as write strobe
//   gnt_o     request accepted this cycle (only in IDLE)
//   rvalid_o  one-cycle completion pulse for reads and writes
//   rdata_o   read data, valid with rvalid_o
//   err_o     error response, valid with rvalid_o
//   master    AXI channels, master modport
//
// Optional feature (macro AXI_LITE_MASTER_ERR_EN):
//   defined   err_o reports any non-OKAY B/R response; read data is zeroed
//             on a read error
//   undefined responses are ignored, err_o is 0, rdata_o is raw r_data
//
// State table:
//   state   | meaning
//   IDLE    | waiting for req_i; grants combinationally and latches request
//   WRITE   | AW and W offered until each has handshaken
//   WRITE_B | waiting for the write response
//   READ_AR | read address offered
//   READ_R  | waiting for the read data
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int unsigned             AXI_ADDR_WIDTH = 64,
  parameter int unsigned             AXI_DATA_WIDTH = 64,
  parameter int unsigned             AXI_ID_WIDTH   = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  axi_lite_master_if.master           master
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WRITE_B = 3'd2,
    READ_AR = 3'd3,
    READ_R  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]     strb_q;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      latch_req;

  // Response sidebands the block never looks at.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{master.b_id, master.b_user, master.b_resp,
                                master.r_id, master.r_user, master.r_resp,
                                master.r_last};

  // Constant AXI fields: single INCR beat of full bus width.
  assign master.aw_id     = AXI_ID;
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = AXI_SIZE;
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_user   = '0;

  assign master.w_data    = wdata_q;
  assign master.w_strb    = strb_q;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;

  assign master.ar_id     = AXI_ID;
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = AXI_SIZE;
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    latch_req       = 1'b0;
    gnt_o           = 1'b0;
    rvalid_d        = 1'b0;
    err_d           = 1'b0;
    rdata_d         = rdata_q;
    master.aw_valid = 1'b0;
    master.w_valid  = 1'b0;
    master.b_ready  = 1'b0;
    master.ar_valid = 1'b0;
    master.r_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          latch_req = 1'b1;
          state_d   = we_i ? WRITE : READ_AR;
        end
      end

      WRITE: begin
        // Each valid is derived from its own done flag, so it can only drop
        // after the matching ready has been seen.
        master.aw_valid = !aw_done_q;
        master.w_valid  = !w_done_q;
        if (!aw_done_q && master.aw_ready) aw_done_d = 1'b1;
        if (!w_done_q && master.w_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)         state_d   = WRITE_B;
      end

      WRITE_B: begin
        master.b_ready = 1'b1;
        if (master.b_valid) begin
          rvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI_LITE_MASTER_ERR_EN
          err_d     = (master.b_resp != 2'b00);
`else
          err_d     = 1'b0;
`endif
          state_d   = IDLE;
        end
      end

      READ_AR: begin
        master.ar_valid = 1'b1;
        if (master.ar_ready) state_d = READ_R;
      end

      READ_R: begin
        master.r_ready = 1'b1;
        if (master.r_valid) begin
          rvalid_d = 1'b1;
`ifdef AXI_LITE_MASTER_ERR_EN
          err_d    = (master.r_resp != 2'b00);
          rdata_d  = (master.r_resp != 2'b00) ? '0 : master.r_data;
`else
          err_d    = 1'b0;
          rdata_d  = master.r_data;
`endif
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      if (latch_req) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        strb_q  <= be_i;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;

`ifdef AXI_LITE_MASTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;

  always #5 clk_i = ~clk_i;

  axi_lite_master_if bus ();

  axi_lite_master #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (10),
    .AXI_ID        (10'd0)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .master  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  logic [63:0] mem [logic [63:0]];
  int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  resp_cfg = 2'b00;
  int          aw_wait, w_wait, b_cnt, r_cnt;
  bit          aw_got, w_got, b_act, r_act;
  logic [63:0] aw_addr_s, w_data_s, ar_addr_s;
  logic [7:0]  w_strb_s, ar_len_s;
  logic [2:0]  ar_size_s;
  logic [1:0]  ar_burst_s;
  logic [9:0]  ar_id_s;
  logic        w_last_s;
  int          n_b = 0, n_r = 0;
  int          aw_vcyc = 0, w_vcyc = 0, b_ready_low = 0, bad_ready = 0;
  int          aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1;

  // All slave activity happens on the falling edge; a handshake decided here
  // takes effect at the following rising edge.
  initial begin
    logic [63:0] tmp;
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
    bus.b_valid = 0; bus.b_resp = 0; bus.b_id = 0; bus.b_user = 0;
    bus.r_valid = 0; bus.r_resp = 0; bus.r_id = 0; bus.r_user = 0;
    bus.r_data = 0; bus.r_last = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.r_valid = 0;
        aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_act = 0; r_act = 0;
        continue;
      end
      // B
      bus.b_valid = 0;
      if (b_act) begin
        if (!bus.b_ready) b_ready_low++;
        if (b_cnt > 0) b_cnt--;
        else begin
          bus.b_valid = 1; bus.b_resp = resp_cfg;
          if (bus.b_ready) begin n_b++; b_act = 0; end
        end
      end else if (bus.b_ready) bad_ready++;
      // R
      bus.r_valid = 0;
      if (r_act) begin
        if (r_cnt > 0) r_cnt--;
        else begin
          bus.r_valid = 1; bus.r_resp = resp_cfg; bus.r_last = 1;
          bus.r_data = mem.exists(ar_addr_s) ? mem[ar_addr_s] : 64'd0;
          if (bus.r_ready) begin n_r++; r_act = 0; end
        end
      end else if (bus.r_ready) bad_ready++;
      // AW
      bus.aw_ready = 0;
      if (bus.aw_valid) begin
        aw_vcyc++;
        if (aw_wait >= aw_delay) begin
          bus.aw_ready = 1; aw_wait = 0; aw_got = 1;
          aw_addr_s = bus.aw_addr; aw_hs_cyc = cyc;
        end else aw_wait++;
      end
      // W
      bus.w_ready = 0;
      if (bus.w_valid) begin
        w_vcyc++;
        if (w_wait >= w_delay) begin
          bus.w_ready = 1; w_wait = 0; w_got = 1;
          w_data_s = bus.w_data; w_strb_s = bus.w_strb; w_last_s = bus.w_last;
          w_hs_cyc = cyc;
        end else w_wait++;
      end
      if (aw_got && w_got) begin
        tmp = mem.exists(aw_addr_s) ? mem[aw_addr_s] : 64'd0;
        for (int i = 0; i < 8; i++)
          if (w_strb_s[i]) tmp[i*8 +: 8] = w_data_s[i*8 +: 8];
        mem[aw_addr_s] = tmp;
        aw_got = 0; w_got = 0; b_act = 1; b_cnt = b_delay;
      end
      // AR
      bus.ar_ready = 0;
      if (bus.ar_valid) begin
        bus.ar_ready = 1; r_act = 1; r_cnt = r_delay;
        ar_addr_s = bus.ar_addr; ar_len_s = bus.ar_len; ar_size_s = bus.ar_size;
        ar_burst_s = bus.ar_burst; ar_id_s = bus.ar_id; ar_hs_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          is_read;
    int          gnt_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int   n_rvalid = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && rvalid_o) begin
        n_rvalid++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: rvalid_o=1 with no pending request (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("err_o", {63'd0, err_o}, {63'd0, e.err});
          if (e.is_read) check("rdata_o", rdata_o, e.rdata);
          if (e.lat >= 0) check("gnt_to_rvalid_latency", 64'(cyc - e.gnt_cyc), 64'(e.lat));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit we, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] be, input logic [63:0] exp_rdata,
                       input logic exp_err, input int lat, output int gcyc);
    exp_t e;
    int   waited = 0;
    @(negedge clk_i);
    req_i = 1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    #1;
    while (!gnt_o && waited < 50) begin
      @(negedge clk_i); #1; waited++;
    end
    if (!gnt_o) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: gnt_o stayed 0 for %0d cycles, expected a grant", waited);
      req_i = 0; gcyc = -1;
      return;
    end
    gcyc = cyc;
    e.rdata = exp_rdata; e.err = exp_err; e.is_read = !we; e.gnt_cyc = cyc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic release_req();
    @(negedge clk_i);
    req_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i); n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g1, g2, nb0, nrv0;
    req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; be_i = 0;
    mem[64'h1000] = 64'hDEADBEEF_CAFEF00D;
    mem[64'h2008] = 64'hAAAAAAAA_BBBBBBBB;
    mem[64'h0]    = 64'h01234567_89ABCDEF;

    repeat (3) @(negedge clk_i);
    #1;
    check("rst_gnt_o", {63'd0, gnt_o}, 64'd0);
    check("rst_rvalid_o", {63'd0, rvalid_o}, 64'd0);
    check("rst_err_o", {63'd0, err_o}, 64'd0);
    check("rst_rdata_o", rdata_o, 64'd0);
    check("rst_valids", {61'd0, bus.aw_valid, bus.w_valid, bus.ar_valid}, 64'd0);
    check("rst_readies", {62'd0, bus.b_ready, bus.r_ready}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1;

    // zero-wait read
    issue(0, 64'h1000, 64'd0, 8'h00, 64'hDEADBEEF_CAFEF00D, 1'b0, 3, g1);
    release_req();
    drain();
    check("ar_addr", ar_addr_s, 64'h1000);
    check("ar_len", {56'd0, ar_len_s}, 64'd0);
    check("ar_size", {61'd0, ar_size_s}, 64'd3);
    check("ar_burst", {62'd0, ar_burst_s}, 64'd1);
    check("ar_id", {54'd0, ar_id_s}, 64'd0);
    check("ar_hs_cycle", 64'(ar_hs_cyc), 64'(g1 + 1));

    // write with W stalled 4 cycles
    nb0 = n_b; nrv0 = n_rvalid; aw_vcyc = 0; w_vcyc = 0; w_delay = 4;
    issue(1, 64'h2008, 64'h55, 8'h0F, 64'd0, 1'b0, 7, g1);
    release_req();
    drain();
    w_delay = 0;
    check("aw_valid_cycles", 64'(aw_vcyc), 64'd1);
    check("w_valid_cycles", 64'(w_vcyc), 64'd5);
    check("w_strb", {56'd0, w_strb_s}, 64'h0F);
    check("w_last", {63'd0, w_last_s}, 64'd1);
    check("b_handshakes", 64'(n_b - nb0), 64'd1);
    check("rvalid_pulses", 64'(n_rvalid - nrv0), 64'd1);
    check("mem_2008", mem[64'h2008], 64'hAAAAAAAA_00000055);

    // simultaneous AW/W, B delayed 3, next request held through WRITE_B
    b_delay = 3; b_ready_low = 0;
    issue(1, 64'h3000, 64'h11112222_33334444, 8'hFF, 64'd0, 1'b0, 6, g1);
    issue(0, 64'h1000, 64'd0, 8'h00, 64'hDEADBEEF_CAFEF00D, 1'b0, 3, g2);
    b_delay = 0;
    release_req();
    drain();
    check("aw_hs_cycle", 64'(aw_hs_cyc), 64'(g1 + 1));
    check("w_hs_cycle", 64'(w_hs_cyc), 64'(g1 + 1));
    check("b_ready_held", 64'(b_ready_low), 64'd0);
    check("gnt_blocked_in_write_b", 64'(g2), 64'(g1 + 6));
    check("mem_3000", mem[64'h3000], 64'h11112222_33334444);

    // back-to-back read then write
    issue(0, 64'h2008, 64'd0, 8'h00, 64'hAAAAAAAA_00000055, 1'b0, 3, g1);
    issue(1, 64'h4000, 64'h0000_0000_0000_CAFE, 8'hFF, 64'd0, 1'b0, 3, g2);
    release_req();
    drain();
    check("b2b_gnt_with_rvalid", 64'(g2), 64'(g1 + 3));
    check("b2b_aw_hs_cycle", 64'(aw_hs_cyc), 64'(g2 + 1));
    check("mem_4000", mem[64'h4000], 64'h0000_0000_0000_CAFE);

    // error responses (SLVERR on read, DECERR on write)
    resp_cfg = 2'b10; r_delay = 2;
    issue(0, 64'h1000, 64'd0, 8'h00, ERR_EN ? 64'd0 : 64'hDEADBEEF_CAFEF00D, ERR_EN, 5, g1);
    release_req();
    drain();
    r_delay = 0; resp_cfg = 2'b11;
    issue(1, 64'h5000, 64'h77, 8'h01, 64'd0, ERR_EN, 3, g1);
    release_req();
    drain();
    resp_cfg = 2'b00;

    // reset in the middle of a write
    aw_delay = 20; w_delay = 20;
    issue(1, 64'h6000, 64'h99, 8'hFF, 64'd0, 1'b0, -1, g1);
    release_req();
    repeat (2) @(negedge clk_i);
    check("pre_rst_aw_valid", {63'd0, bus.aw_valid}, 64'd1);
    #2 rst_ni = 0;
    #1;
    check("async_rst_aw_valid", {63'd0, bus.aw_valid}, 64'd0);
    check("async_rst_w_valid", {63'd0, bus.w_valid}, 64'd0);
    check("async_rst_b_ready", {63'd0, bus.b_ready}, 64'd0);
    exp_q.delete();
    aw_delay = 0; w_delay = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    issue(0, 64'h0, 64'd0, 8'h00, 64'h01234567_89ABCDEF, 1'b0, 3, g1);
    release_req();
    drain();
    check("post_rst_ar_addr", ar_addr_s, 64'h0);

    check("ready_outside_txn", 64'(bad_ready), 64'd0);
    check("total_rvalid", 64'(n_rvalid), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Initiator-side counterpart of the team's AXI4-Lite slave adapter.
- Converts a simple memory-like request/grant/response interface (core or debug side) into single-beat AXI4-Lite read and write transactions on an AXI_BUS master port.
- Supports one transaction in flight at a time; write address and write data channels are handshaken independently.
- Sits between a timer/peripheral-access requester and the AXI interconnect.

Parameters:
- AXI_ADDR_WIDTH, 64, address width of the request side and AXI side.
- AXI_DATA_WIDTH, 64, data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 10, ID width.
- AXI_ID, 0, constant ID driven on aw_id and ar_id.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  1  request valid; held until gnt_o.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  AXI_ADDR_WIDTH  byte address.
- wdata_i  input  AXI_DATA_WIDTH  write data.
- be_i  input  AXI_DATA_WIDTH/8  byte enables (write strobe).
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  one-cycle completion pulse for reads and writes.
- rdata_o  output  AXI_DATA_WIDTH  read data, valid with rvalid_o.
- err_o  output  1  error response, valid with rvalid_o.
- master  interface  AXI_BUS.Master  AXI4-Lite channels.

Behaviour:
- Clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - FSM is IDLE.
  - All AXI valid and ready outputs are 0.
  - gnt_o, rvalid_o and err_o are 0; rdata_o is 0.
  - Internal registers (addr, data, strb, done flags) are 0.
- Constant AXI fields on AW and AR:
  - len = 0; size = $clog2(AXI_DATA_WIDTH/8); burst = INCR (2'b01).
  - prot, cache, lock, qos, region, user = 0.
  - id = AXI_ID.
- Constant AXI fields on W: w_last = 1; w_user = 0.
- States:
  - IDLE: gnt_o = req_i (combinational).
    - On req_i: latch addr_i, wdata_i and be_i.
    - we_i = 1 goes to WRITE; we_i = 0 goes to READ_AR.
  - WRITE:
    - aw_valid = !aw_done, w_valid = !w_done; aw_addr, w_data and w_strb come from the latched values.
    - aw_done and w_done set on their respective handshakes.
    - Go to WRITE_B once both are done, including the case where both complete in the same cycle or in different cycles.
    - Once asserted, a valid is never deasserted before its ready.
  - WRITE_B: b_ready = 1. On b_valid, capture b_resp, clear the done flags, go to IDLE.
  - READ_AR: ar_valid = 1 with the latched address. On ar_ready go to READ_R.
  - READ_R: r_ready = 1. On r_valid, capture r_data and r_resp, go to IDLE.
- Response output:
  - rvalid_o is registered and asserts for exactly one cycle, in the cycle after the B or R handshake.
  - rdata_o holds the captured r_data until the next read completes; its value is don't-care after writes.
  - A new request may be granted in the same cycle rvalid_o is high.
- Latency with zero-wait slave:
  - Read: gnt at cycle 0, ar handshake at cycle 1, earliest r handshake at cycle 2, rvalid_o at cycle 3.
  - Write: gnt at cycle 0, aw and w at cycle 1, b at cycle 2, rvalid_o at cycle 3.
- Other rules:
  - req_i is ignored in every state except IDLE.
  - Unexpected b_valid or r_valid in the wrong state is not acknowledged (ready stays 0).
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and all valids drop.
  - The slave side must be reset concurrently; system-level reset only.

Optional Feature:
- Macro AXI_LITE_MASTER_ERR_EN.
- Defined: err_o = (captured resp != 2'b00) during rvalid_o. SLVERR and DECERR are both reported. On a read error rdata_o is forced to 0.
- Undefined: resp fields are ignored, err_o is tied to 0, and rdata_o always carries r_data.

Test Plan:
- Read, zero-wait memory model: req at addr 0x1000 holding 0xDEADBEEF_CAFEF00D → ar_addr = 0x1000, ar_len = 0, ar_size = 3; rvalid_o 3 cycles after gnt; rdata_o = 0xDEADBEEF_CAFEF00D; err_o = 0.
- Write with w_ready stalled 4 cycles and aw_ready immediate: write 0x55 to 0x2008, be = 8'h0F.
  - aw_valid drops after 1 cycle; w_valid is held for 5 cycles with w_strb = 0x0F and w_last = 1.
  - Exactly one b handshake, one rvalid_o pulse, and memory[0x2008] low 4 bytes = 0x00000055.
- Simultaneous AW/W handshake with b_valid delayed 3 cycles → b_ready is high throughout WRITE_B; gnt_o is 0 while req_i is held during WRITE_B.
- Back-to-back: read followed by a write held on req_i → second gnt_o coincides with the first rvalid_o; no idle AXI cycle beyond the FSM minimum.
- With AXI_LITE_MASTER_ERR_EN, slave returns r_resp = 2'b10 → err_o = 1 and rdata_o = 0; without the macro, err_o = 0 and rdata_o = the slave data.
- rst_ni pulsed low while in WRITE with aw_valid high → aw_valid, w_valid and b_ready are 0 asynchronously; after release, a read at 0x0 completes normally.
